// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES definitions for the permutation engine:
//   DES_BLK_W / DES_HALF_W  block and half-block widths
//   DES_IP_TBL / DES_FP_TBL initial and final permutation tables. Entry k-1
//                           holds the source DES bit for output DES bit k.
//                           DES bit 1 is the MSB (vector bit 63).
//   des_perm_mode_e         per-transaction permutation select
//   des_permute()           applies the selected table to a 64-bit block
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  localparam int DES_IP_TBL [DES_BLK_W] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int DES_FP_TBL [DES_BLK_W] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  typedef enum logic {
    DES_PERM_IP = 1'b0,
    DES_PERM_FP = 1'b1
  } des_perm_mode_e;

  // Pure wiring once the loop unrolls: every output bit is one input bit.
  // DES bit n lives at vector index 64-n.
  function automatic logic [DES_BLK_W-1:0] des_permute(
    input logic [DES_BLK_W-1:0] blk,
    input des_perm_mode_e       mode
  );
    logic [DES_BLK_W-1:0] res;
    int                   src;
    res = '0;
    for (int k = 0; k < DES_BLK_W; k++) begin
      src = (mode == DES_PERM_IP) ? DES_IP_TBL[k] : DES_FP_TBL[k];
      res[6'(DES_BLK_W - 1 - k)] = blk[6'(DES_BLK_W - src)];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_perm_stage.sv
// -----------------------------------------------------------------------------
// des_perm_stage
// One register slot of the permutation pipeline: a valid flop plus a payload
// register, with bubble-collapsing ready chaining (a stage accepts whenever it
// is empty or its downstream neighbour accepts).
//
// Parameters:
//   PW    payload width (result, plus tag when tags are built in)
//   LAST  1 for the output stage: payload is reset to zero and only loads
//         when a valid entry arrives, so the outputs keep the last result
//         across bubbles. Inner stages carry no payload reset.
// Ports:
//   clk_in      clock, rising edge
//   rst_n_in    asynchronous active-low reset (clears valid, LAST payload)
//   i_up_valid  valid from upstream
//   i_up_data   payload from upstream
//   i_dn_ready  ready of the downstream neighbour (or the pipe consumer)
//   o_ready     this stage can load this cycle
//   o_valid     this stage holds a valid entry
//   o_data      payload register
// -----------------------------------------------------------------------------
module des_perm_stage #(
  parameter int PW   = 64,
  parameter bit LAST = 1'b0
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          i_up_valid,
  input  logic [PW-1:0] i_up_data,
  input  logic          i_dn_ready,
  output logic          o_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_vld;
  logic [PW-1:0] r_pay;

  // Empty slots accept regardless of downstream, which squeezes bubbles out.
  assign o_ready = !r_vld || i_dn_ready;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld <= 1'b0;
    end else if (o_ready) begin
      r_vld <= i_up_valid;
    end
  end

  if (LAST) begin : g_last
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_pay <= '0;
      end else if (o_ready && i_up_valid) begin
        r_pay <= i_up_data;
      end
    end
  end else begin : g_inner
    // Payload of an empty inner slot is don't-care, so no reset is needed.
    always_ff @(posedge clk_in) begin
      if (o_ready) begin
        r_pay <= i_up_data;
      end
    end
  end

  assign o_valid = r_vld;
  assign o_data  = r_pay;

endmodule

// File: rtl/des_perm_pipe.sv
// -----------------------------------------------------------------------------
// des_perm_pipe
// Pipelined DES initial / final permutation engine with valid/ready flow
// control. The permutation is combinational ahead of stage 0; STAGES
// bubble-collapsing register slots follow, and the outputs come straight
// from the last slot's flops.
//
// Build option: define DES_PERM_TAG_EN to add tag_in/tag_out, a sideband tag
// that travels with each block. Without it there are no tag ports or flops
// and TAG_W has no effect.
//
// Parameters:
//   STAGES  register stages between input and output, 1..8
//   TAG_W   tag width (tag build only)
// Ports:
//   clk_in          clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   data_in         64-bit block, data_in[63] = DES bit 1
//   mode_in         0 = IP, 1 = IP^-1 (input is the preoutput R16||L16)
//   data_in_valid   input valid
//   data_in_ready   engine accepts this cycle
//   tag_in          sideband tag in (tag build only)
//   tag_out         tag aligned with result (tag build only)
//   left_data_out   result bits [63:32]
//   right_data_out  result bits [31:0]
//   data_out_valid  result valid
//   data_out_ready  downstream accepts
//   busy_out        any stage holds a valid entry
// -----------------------------------------------------------------------------
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DES_BLK_W-1:0]  data_in,
  input  logic                  mode_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
`ifdef DES_PERM_TAG_EN
  input  logic [TAG_W-1:0]      tag_in,
  output logic [TAG_W-1:0]      tag_out,
`endif
  output logic [DES_HALF_W-1:0] left_data_out,
  output logic [DES_HALF_W-1:0] right_data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  busy_out
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "des_perm_pipe: STAGES=%0d is outside 1..8", STAGES);
  end

`ifdef DES_PERM_TAG_EN
  localparam int PW = DES_BLK_W + TAG_W;
`else
  // TAG_W is kept as a parameter for a uniform interface but contributes
  // no bits in this build.
  localparam int PW = DES_BLK_W + (0 * TAG_W);
`endif

  // Index s of these vectors is the input side of stage s; index STAGES is
  // the pipe output side.
  logic [STAGES:0] w_vld;
  logic [STAGES:0] w_rdy;
  logic [PW-1:0]   w_pay [STAGES+1];
  logic [DES_BLK_W-1:0] w_perm_p0;

  // ---- combinational permutation, ahead of stage 0 ----
  assign w_perm_p0 = des_permute(data_in, des_perm_mode_e'(mode_in));

`ifdef DES_PERM_TAG_EN
  assign w_pay[0] = {tag_in, w_perm_p0};
`else
  assign w_pay[0] = w_perm_p0;
`endif
  assign w_vld[0]       = data_in_valid;
  assign w_rdy[STAGES]  = data_out_ready;

  // ---- register stages 0..STAGES-1 ----
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    des_perm_stage #(
      .PW   (PW),
      .LAST (s == STAGES - 1)
    ) u_stage (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .i_up_valid (w_vld[s]),
      .i_up_data  (w_pay[s]),
      .i_dn_ready (w_rdy[s+1]),
      .o_ready    (w_rdy[s]),
      .o_valid    (w_vld[s+1]),
      .o_data     (w_pay[s+1])
    );
  end

  // ---- outputs, straight from the last stage's flops ----
  // data_in_ready depends on stage valids and data_out_ready only, never on
  // data_in_valid.
  assign data_in_ready  = w_rdy[0];
  assign data_out_valid = w_vld[STAGES];
  assign left_data_out  = w_pay[STAGES][DES_BLK_W-1:DES_HALF_W];
  assign right_data_out = w_pay[STAGES][DES_HALF_W-1:0];
  assign busy_out       = |w_vld[STAGES:1];
`ifdef DES_PERM_TAG_EN
  assign tag_out        = w_pay[STAGES][PW-1:DES_BLK_W];
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
module tb_des_perm_pipe;

  localparam int STAGES = 4;
  localparam int TAG_W  = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [63:0] data_in;
  logic        mode_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] left_data_out;
  logic [31:0] right_data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        busy_out;
`ifdef DES_PERM_TAG_EN
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
`endif

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [63:0]      exp_q[$];
`ifdef DES_PERM_TAG_EN
  logic [TAG_W-1:0] exp_tag_q[$];
`endif

  always #5 clk_in = ~clk_in;

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .data_in        (data_in),
    .mode_in        (mode_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
`ifdef DES_PERM_TAG_EN
    .tag_in         (tag_in),
    .tag_out        (tag_out),
`endif
    .left_data_out  (left_data_out),
    .right_data_out (right_data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy_out       (busy_out)
  );

  // Reference: the IP table is generated from its row/column structure
  // (rows start 58,60,62,64,57,59,61,63 and step down by 8), and IP^-1 is
  // obtained by inverting that mapping rather than from a second table.
  function automatic int ip_src(input int k);
    int r;
    int c;
    r = (k - 1) / 8;
    c = (k - 1) % 8;
    return ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] b, input logic m);
    logic [63:0] o;
    int s;
    o = '0;
    for (int k = 1; k <= 64; k++) begin
      s = ip_src(k);
      if (!m) o[6'(64 - k)] = b[6'(64 - s)];
      else    o[6'(64 - s)] = b[6'(64 - k)];
    end
    return o;
  endfunction

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endfunction

  // Scoreboard: record accepted blocks, compare every valid output cycle,
  // retire an entry when the consumer takes it.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      exp_q.delete();
`ifdef DES_PERM_TAG_EN
      exp_tag_q.delete();
`endif
    end else begin
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", {left_data_out, right_data_out}, 64'hx);
        end else begin
          check("stream_out", {left_data_out, right_data_out}, exp_q[0]);
`ifdef DES_PERM_TAG_EN
          check("stream_tag", 64'(tag_out), 64'(exp_tag_q[0]));
`endif
          if (data_out_ready) begin
            void'(exp_q.pop_front());
`ifdef DES_PERM_TAG_EN
            void'(exp_tag_q.pop_front());
`endif
            n_out++;
          end
        end
      end
      if (data_in_valid && data_in_ready) begin
        exp_q.push_back(ref_perm(data_in, mode_in));
`ifdef DES_PERM_TAG_EN
        exp_tag_q.push_back(tag_in);
`endif
      end
    end
  end

  // One block into an empty pipe; measures latency and checks the value.
  task automatic run_one(input string name, input logic [63:0] d,
                         input logic m, input logic [63:0] exp);
    int n;
    n = 0;
    @(posedge clk_in); #1;
    data_in = d; mode_in = m; data_in_valid = 1'b1; data_out_ready = 1'b1;
`ifdef DES_PERM_TAG_EN
    tag_in = TAG_W'($urandom);
`endif
    do begin
      @(posedge clk_in); #1;
      n++;
      data_in_valid = 1'b0;
    end while (!data_out_valid && n < 50);
    check({name, "_latency"}, 64'(n), 64'(STAGES));
    check({name, "_value"}, {left_data_out, right_data_out}, exp);
    @(posedge clk_in); #1;
  endtask

  // Offer random blocks (mode alternating per accepted block) until nblk are
  // accepted or the cycle budget runs out.
  task automatic push_blocks(input int nblk, input int budget,
                             input bit chk_ready, output int acc);
    int   cyc;
    logic ok;
    acc = 0;
    cyc = 0;
    data_in = {$urandom, $urandom}; mode_in = 1'b0; data_in_valid = 1'b1;
`ifdef DES_PERM_TAG_EN
    tag_in = TAG_W'($urandom);
`endif
    while (acc < nblk && cyc < budget) begin
      @(negedge clk_in);
      ok = data_in_ready;
      if (chk_ready) check("stream_in_ready", 64'(data_in_ready), 64'd1);
      @(posedge clk_in); #1;
      cyc++;
      if (ok) begin
        acc++;
        data_in = {$urandom, $urandom};
        mode_in = acc[0];
`ifdef DES_PERM_TAG_EN
        tag_in = TAG_W'($urandom);
`endif
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    data_out_ready = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk_in); #1;
      c++;
    end
    @(posedge clk_in); #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(busy_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, acc3, base;
    logic [63:0] d;
    rst_n_in = 1'b0; data_in = '0; mode_in = 1'b0;
    data_in_valid = 1'b0; data_out_ready = 1'b1;
`ifdef DES_PERM_TAG_EN
    tag_in = '0;
`endif

    // Model pinned against hand-known vectors.
    check("model_ip", ref_perm(64'h0123456789ABCDEF, 1'b0), 64'hCC00CCFFF0AAF0AA);
    check("model_fp", ref_perm(64'hCC00CCFFF0AAF0AA, 1'b1), 64'h0123456789ABCDEF);
    check("model_bit1", ref_perm(64'h8000000000000000, 1'b0), 64'h0000000001000000);

    // Reset state.
    repeat (2) @(posedge clk_in); #1;
    check("rst_out_valid", 64'(data_out_valid), 64'd0);
    check("rst_out_data", {left_data_out, right_data_out}, 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
`ifdef DES_PERM_TAG_EN
    check("rst_tag", 64'(tag_out), 64'd0);
`endif
    @(negedge clk_in); rst_n_in = 1'b1;
    #1 check("rst_in_ready", 64'(data_in_ready), 64'd1);

    // Directed vectors.
    run_one("ip_vec", 64'h0123456789ABCDEF, 1'b0, 64'hCC00CCFFF0AAF0AA);
    run_one("fp_vec", 64'hCC00CCFFF0AAF0AA, 1'b1, 64'h0123456789ABCDEF);
    run_one("ip_bit1", 64'h8000000000000000, 1'b0, 64'h0000000001000000);
    drain("directed", 20);

    // Back-to-back mixed modes, no backpressure.
    base = n_out;
    push_blocks(16, 40, 1'b1, acc);
    check("stream_accepts", 64'(acc), 64'd16);
    drain("stream", 40);
    check("stream_outputs", 64'(n_out - base), 64'd16);

    // Backpressure: pipe fills after exactly STAGES accepts.
    base = n_out;
    data_out_ready = 1'b0;
    push_blocks(20, 10, 1'b0, acc);
    check("bp_accepts", 64'(acc), 64'(STAGES));
    @(negedge clk_in);
    check("bp_in_ready", 64'(data_in_ready), 64'd0);
    check("bp_out_valid", 64'(data_out_valid), 64'd1);
    check("bp_busy", 64'(busy_out), 64'd1);
    drain("bp", 40);
    check("bp_outputs", 64'(n_out - base), 64'(STAGES));

    // Bubble collapse: one block in flight, then stall the consumer.
    push_blocks(1, 10, 1'b0, acc);
    data_out_ready = 1'b0;
    push_blocks(20, 3, 1'b0, acc2);
    push_blocks(20, 2, 1'b0, acc3);
    check("bubble_accepts", 64'(acc + acc2 + acc3), 64'd4);
    @(negedge clk_in);
    check("bubble_in_ready", 64'(data_in_ready), 64'd0);
    drain("bubble", 40);

    // Reset with blocks in flight.
    data_out_ready = 1'b0;
    push_blocks(3, 10, 1'b0, acc);
    check("rstmid_accepts", 64'(acc), 64'd3);
    @(posedge clk_in); #3;
    rst_n_in = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(data_out_valid), 64'd0);
    check("rstmid_out_data", {left_data_out, right_data_out}, 64'd0);
    check("rstmid_busy", 64'(busy_out), 64'd0);
`ifdef DES_PERM_TAG_EN
    check("rstmid_tag", 64'(tag_out), 64'd0);
`endif
    @(posedge clk_in); #2;
    rst_n_in = 1'b1;
    data_out_ready = 1'b1;
    d = {$urandom, $urandom};
    run_one("post_rst", d, 1'b1, ref_perm(d, 1'b1));
    drain("final", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised, pipelined DES bit-permutation engine. Each transaction applies either the initial permutation (IP) or the final permutation (IP^-1) to a 64-bit block.
- Sits at both ends of the DES round datapath. Mode is selected per transaction, so one instance serves encrypt-entry and decrypt-exit paths.
- Full valid/ready flow control with bubble collapsing through STAGES register stages.

Parameters:
- STAGES, 2, number of register stages between input and output; legal range 1..8.
- TAG_W, 4, width of the sideband tag; only used when DES_PERM_TAG_EN is defined.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- data_in  input  64  block in; data_in[63] is DES bit 1, data_in[0] is DES bit 64.
- mode_in  input  1  0 = IP, 1 = IP^-1.
- data_in_valid  input  1  input transaction valid.
- data_in_ready  output  1  engine can accept this cycle.
- tag_in  input  TAG_W  sideband tag; present only with DES_PERM_TAG_EN.
- left_data_out  output  32  result bits [63:32].
- right_data_out  output  32  result bits [31:0].
- data_out_valid  output  1  result valid.
- data_out_ready  input  1  downstream accepts.
- tag_out  output  TAG_W  tag aligned with result; present only with DES_PERM_TAG_EN.
- busy_out  output  1  any stage holds valid data.

Behaviour:
- IP mapping: output DES bit k = input DES bit IP[k], using the standard FIPS-46 table (58,50,42,...,7). Example: left[31] = data_in[6]; right[24] = data_in[63].
- IP^-1 mapping: standard FIPS-46 inverse table (40,8,48,...,25).
- IP^-1 input is the preoutput block R16||L16. The caller performs the swap; this block does not.
- Permutation is purely combinational, applied before stage 0. Stage s holds {valid_s, result_s, tag_s}.
- Acceptance: a transfer occurs when data_in_valid && data_in_ready.
- Bubble-collapsing advance rule:
  - ready_last = !valid_last || data_out_ready.
  - ready_s = !valid_s || ready_{s+1}.
  - data_in_ready = ready_0.
  - No combinational path from data_in_valid to data_in_ready.
- Stage update: a stage loads from upstream when ready_s is high. Its valid becomes the upstream valid (data_in_valid for stage 0). When ready_s is low, the stage holds all fields.
- Outputs come directly from the last stage's registers, with no combinational logic after the registers.
- data_out_valid = valid_last. While data_out_valid && !data_out_ready, left/right/tag_out are held stable.
- Latency: STAGES cycles from an accepted input to data_out_valid, when there is no backpressure.
- Throughput: 1 block per cycle when data_out_ready is held high.
- Payload holding on bubbles: the payload registers of an invalid stage may load don't-care data. Exception: the last stage's payload is not updated when it loads an invalid entry (clock-enable = upstream valid), so the outputs keep the last result. This matches the existing hold-last-value behaviour.
- Ordering is strictly FIFO. Mode travels with each block, so mixed IP and IP^-1 streams are legal back-to-back.
- Simultaneous accept at stage 0 and drain at the output in the same cycle is legal with a full pipe. No data loss or duplication.
- Reset: all valid bits = 0; left/right_data_out = 0; tag_out = 0; data_out_valid = 0; busy_out = 0; data_in_ready = 1 once reset is released.
- Reset asserted mid-operation discards all in-flight blocks immediately, asynchronously.
- busy_out = OR of all stage valid bits, registered-equivalent (derived only from flops).
- Elaboration: STAGES outside 1..8 triggers $fatal.

Optional Feature:
- Macro: DES_PERM_TAG_EN.
- Defined: tag_in/tag_out ports exist. The tag is pipelined alongside its block under the same enable rules. tag_out resets to 0 and holds under backpressure.
- Undefined: no tag ports and no tag flops. TAG_W is ignored.

Decomposition:
- Package des_pkg contains:
  - localparam DES_BLK_W = 64 and DES_HALF_W = 32.
  - Constant arrays DES_IP_TBL[64] and DES_FP_TBL[64], 1-based DES numbering.
  - typedef enum logic {DES_PERM_IP = 1'b0, DES_PERM_FP = 1'b1} des_perm_mode_e.
  - Function des_permute(blk, mode) returning 64 bits.
- Sub-module des_perm_stage: one valid/payload register with the ready-chaining logic. It is instantiated STAGES times via generate.

Test Plan:
- IP vector: data_in=64'h0123456789ABCDEF, mode=0, data_out_ready=1 -> after STAGES cycles left=32'hCC00CCFF, right=32'hF0AAF0AA.
- IP^-1 vector: data_in=64'hCC00CCFFF0AAF0AA, mode=1 -> {left,right}=64'h0123456789ABCDEF. Then a single-bit check: data_in=64'h8000_0000_0000_0000, mode=0 -> left=0, right=32'h01000000.
- Streaming mixed modes: 16 back-to-back random blocks with alternating mode, ready=1 -> 16 results in order vs a reference model, one per cycle, data_in_ready never low.
- Backpressure: fill the pipe with data_out_ready=0 -> data_in_ready falls after exactly STAGES accepts and outputs stay stable. Release ready -> all blocks drain in order with no loss or duplication.
- Bubble collapse: STAGES=4, one block accepted, then data_out_ready=0 for 3 cycles while sending more -> 4 blocks total accepted before data_in_ready=0.
- Reset mid-stream: assert rst_n_in with 3 blocks in flight -> data_out_valid=0, outputs=0, busy_out=0 immediately. After release, the first new block emerges after STAGES cycles with a correct value (and tag with DES_PERM_TAG_EN).
